load_store_unit: RTL

Parametrised load/store unit between the execute stage and a data memory or IO port with handshaked, variable-latency access. It generates byte enables and lane-replicated write data, and extracts and sign- or zero-extends load data. The execute stage stalls on `req_ready` low, which replaces the fixed single-cycle block-RAM timing of the current pipeline.

---
 rtl/lsu_pkg.sv | 11 +
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM state type and byte-offset-to-lane mapping for the load/store unit
package lsu_pkg;
  localparam logic [1:0] LSU_BYTE  = 2'd0;
  localparam logic [1:0] LSU_HALF  = 2'd1;
  localparam logic [1:0] LSU_WORD  = 2'd2;
  localparam logic [1:0] LSU_DWORD = 2'd3;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} lsu_state_t;
  function automatic int lsu_lane(input int off, input bit big_endian, input int bytes);
    return big_endian ? bytes - 1 - off : off;
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables and replicated store data for a request; lane extraction and extension of load data
//   request side : i_size, i_off, i_wdata -> o_be, o_wdata, o_misalign
//   response side: i_rsize, i_roff, i_rsigned, i_rdata -> o_rdata
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int BIG_ENDIAN = 1,
  localparam int BYTES     = DATA_W / 8,
  localparam int OFF_W     = $clog2(BYTES)
) (
  input  logic [1:0]        i_size,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [BYTES-1:0]  o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_misalign,
  input  logic [1:0]        i_rsize,
  input  logic [OFF_W-1:0]  i_roff,
  input  logic              i_rsigned,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_rdata
);
  function automatic logic [1:0] eff_size(input logic [1:0] s);
    return (DATA_W == 32 && s == LSU_DWORD) ? LSU_WORD : s;
  endfunction
  // lowest-numbered lane touched by the naturally aligned access
  function automatic int low_lane(input logic [1:0] s, input logic [OFF_W-1:0] off);
    int n, a;
    n = 1 << eff_size(s);
    a = int'(off) & ~(n - 1);
    return BIG_ENDIAN != 0 ? lsu_lane(a + n - 1, 1'b1, BYTES) : a;
  endfunction
  logic [1:0] w_sz, w_rsz;
  logic [DATA_W-1:0] w_sh, w_up;
  logic signed [DATA_W-1:0] w_sx;
  int w_n, w_lo, w_rlo, w_k;
  always_comb begin
    w_sz = eff_size(i_size);
    w_n = 1 << w_sz;
    w_lo = low_lane(i_size, i_off);
    o_misalign = (int'(i_off) & (w_n - 1)) != 0;
    for (int i = 0; i < BYTES; i++) o_be[i] = i >= w_lo && i < w_lo + w_n;
    o_wdata = w_sz == LSU_BYTE ? {BYTES{i_wdata[7:0]}}
            : w_sz == LSU_HALF ? {(BYTES / 2){i_wdata[15:0]}}
            : w_sz == LSU_WORD ? {(BYTES / 4){i_wdata[31:0]}} : i_wdata;
    w_rsz = eff_size(i_rsize);
    w_rlo = low_lane(i_rsize, i_roff);
    w_k = DATA_W - (8 << w_rsz);
    // park the selected lanes at the top, then shift back down to extend
    w_sh = i_rdata >> (8 * w_rlo);
    w_up = w_sh << w_k;
    w_sx = $signed(w_up) >>> w_k;
    o_rdata = i_rsigned ? w_sx : w_up >> w_k;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: handshaked, variable-latency load/store unit between execute and data memory
//   request : req_valid/req_ready, req_we, req_size, req_signed, req_addr, req_wdata, req_rd
//   memory  : mem_req_valid/mem_req_ready, mem_we, mem_be, mem_addr, mem_wdata, mem_rsp_valid, mem_rdata
//   response: rsp_valid, rsp_data, rsp_rd, rsp_err (only with LSU_MISALIGN_TRAP_EN)
//   LSU_MISALIGN_TRAP_EN: misaligned requests complete with rsp_err instead of being force-aligned
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 1,
  localparam int BYTES     = DATA_W / 8,
  localparam int OFF_W     = $clog2(BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_signed,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  input  logic [4:0]              req_rd,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_we,
  output logic [BYTES-1:0]        mem_be,
  output logic [ADDR_W-OFF_W-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic                    rsp_err,
`endif
  output logic [4:0]              rsp_rd
);
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  lsu_state_t r_state, w_next;
  logic r_we, r_signed, r_err, r_mem_req_valid, r_mem_we, r_rsp_valid;
  logic [1:0] r_size;
  logic [OFF_W-1:0] r_off;
  logic [4:0] r_rd, r_rsp_rd;
  logic [BYTES-1:0] r_mem_be, w_be;
  logic [ADDR_W-OFF_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_rsp_data, w_wdata, w_rdata;
  logic w_mis, w_accept, w_err;
  lsu_align #(.DATA_W(DATA_W), .BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .i_size    (req_size),
    .i_off     (req_addr[OFF_W-1:0]),
    .i_wdata   (req_wdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_misalign(w_mis),
    .i_rsize   (r_size),
    .i_roff    (r_off),
    .i_rsigned (r_signed),
    .i_rdata   (mem_rdata),
    .o_rdata   (w_rdata)
  );
  // a trapped request still passes through ISSUE but never raises mem_req_valid
  always_comb begin
    w_accept = r_state == IDLE && req_valid;
    w_err = r_state == IDLE ? TRAP_EN && w_mis : r_err;
    w_next = r_state == IDLE  ? (req_valid ? ISSUE : IDLE)
           : r_state == ISSUE ? (r_err ? DONE : mem_req_ready ? (r_we ? DONE : WAIT) : ISSUE)
           : r_state == WAIT  ? (mem_rsp_valid ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req_valid <= 1'b0;
      r_mem_we <= 1'b0;
      r_mem_be <= '0;
      r_mem_addr <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_rd <= '0;
      r_we <= 1'b0;
      r_signed <= 1'b0;
      r_err <= 1'b0;
      r_size <= '0;
      r_off <= '0;
      r_rd <= '0;
    end else begin
      r_mem_req_valid <= w_next == ISSUE && !w_err;
      r_rsp_valid <= w_next == DONE;
      if (w_accept) begin
        r_mem_we <= req_we;
        r_mem_be <= w_be;
        r_mem_addr <= req_addr[ADDR_W-1:OFF_W];
        r_mem_wdata <= w_wdata;
        r_rsp_data <= '0;
        r_we <= req_we;
        r_signed <= req_signed;
        r_err <= w_err;
        r_size <= req_size;
        r_off <= req_addr[OFF_W-1:0];
        r_rd <= req_rd;
      end
      if (r_state == WAIT && mem_rsp_valid) r_rsp_data <= w_rdata;
      if (w_next == DONE) r_rsp_rd <= r_we && !r_err ? '0 : r_rd;
    end
  end
`ifdef LSU_MISALIGN_TRAP_EN
  logic r_rsp_err;
  always_ff @(posedge clk) begin
    if (rst) r_rsp_err <= 1'b0;
    else r_rsp_err <= w_next == DONE && r_err;
  end
  assign rsp_err = r_rsp_err;
`endif
  assign req_ready = r_state == IDLE;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_we = r_mem_we;
  assign mem_be = r_mem_be;
  assign mem_addr = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data = r_rsp_data;
  assign rsp_rd = r_rsp_rd;
endmodule
